// File: rtl/calc_seq_if.sv
// Button/switch, RF-control and ALU-handshake signals of the calculator sequencer.
// The slave modport is the sequencer side; the master modport is the board/datapath side.
interface calc_seq_if #(
    parameter int unsigned OP_W = 3
);
    logic            next_btn;
    logic [OP_W-1:0] MS;
    logic            alu_done;
    logic            rf_we;
    logic            W1;
    logic            rf_wsel;
    logic            alu_start;
    logic [OP_W-1:0] MS_out;
    logic            Done_out;
    logic            err;
    logic [2:0]      CS_out;

    modport master (
        output next_btn, MS, alu_done,
        input  rf_we, W1, rf_wsel, alu_start, MS_out, Done_out, err, CS_out
    );

    modport slave (
        input  next_btn, MS, alu_done,
        output rf_we, W1, rf_wsel, alu_start, MS_out, Done_out, err, CS_out
    );
endinterface

// File: rtl/calc_sequencer.sv
// Control FSM for the two-operand calculator: RF operand writes, ALU launch/timeout, result valid.
// Define CALC_CHAIN_EN to let a press on a good result write it back into RF[0] and chain on.
module calc_sequencer #(
    parameter int unsigned OP_W        = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input logic       CLK,
    input logic       clear_n,
    calc_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(ALU_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle1 = 3'd0,
        StIn1   = 3'd1,
        StIdle2 = 3'd2,
        StIn2   = 3'd3,
        StIdle3 = 3'd4,
        StStart = 3'd5,
        StWait  = 3'd6,
        StDone  = 3'd7
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_dly_q, btn_dly_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic                   err_q, err_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   rf_we_q, rf_we_d;
    logic                   w1_q, w1_d;
    logic                   alu_start_q, alu_start_d;
    logic [OP_W-1:0]        ms_out_q, ms_out_d;
    logic                   done_q, done_d;
    logic                   press;
`ifdef CALC_CHAIN_EN
    logic                   rf_wsel_q, rf_wsel_d;
`endif

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.next_btn};
        btn_dly_d = sync_q[SYNC_STAGES-1];
        press     = sync_q[SYNC_STAGES-1] & ~btn_dly_q;
        state_d   = state_q;
        op_d      = op_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
`ifdef CALC_CHAIN_EN
        rf_wsel_d = 1'b0;
`endif
        unique case (state_q)
            StIdle1: if (press) state_d = StIn1;
            StIn1:   state_d = StIdle2;
            StIdle2: if (press) state_d = StIn2;
            StIn2:   state_d = StIdle3;
            StIdle3: begin
                if (press) begin
                    op_d = bus.MS;
                    if (bus.MS != '0) begin
                        state_d = StStart;
                    end else begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StStart: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                // A done on the last allowed cycle beats the timeout.
                if (bus.alu_done) begin
                    state_d = StDone;
                    err_d   = 1'b0;
                end else if (cnt_q == CntW'(ALU_TIMEOUT - 1)) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (press) begin
                    err_d = 1'b0;
`ifdef CALC_CHAIN_EN
                    if (!err_q) begin
                        state_d   = StIn1;
                        rf_wsel_d = 1'b1;
                    end else begin
                        state_d = StIdle1;
                    end
`else
                    state_d = StIdle1;
`endif
                end
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        rf_we_d     = (state_d == StIn1) || (state_d == StIn2);
        w1_d        = (state_d == StIdle2) || (state_d == StIn2);
        alu_start_d = (state_d == StStart);
        done_d      = (state_d == StDone);
        ms_out_d    = ((state_d == StStart) || (state_d == StWait) || (state_d == StDone)) ?
                      op_d : '0;
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= StIdle1;
            sync_q      <= '0;
            btn_dly_q   <= 1'b0;
            op_q        <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rf_we_q     <= 1'b0;
            w1_q        <= 1'b0;
            alu_start_q <= 1'b0;
            ms_out_q    <= '0;
            done_q      <= 1'b0;
`ifdef CALC_CHAIN_EN
            rf_wsel_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            btn_dly_q   <= btn_dly_d;
            op_q        <= op_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rf_we_q     <= rf_we_d;
            w1_q        <= w1_d;
            alu_start_q <= alu_start_d;
            ms_out_q    <= ms_out_d;
            done_q      <= done_d;
`ifdef CALC_CHAIN_EN
            rf_wsel_q   <= rf_wsel_d;
`endif
        end
    end

    assign bus.rf_we     = rf_we_q;
    assign bus.W1        = w1_q;
    assign bus.alu_start = alu_start_q;
    assign bus.MS_out    = ms_out_q;
    assign bus.Done_out  = done_q;
    assign bus.err       = err_q;
    assign bus.CS_out    = state_q;
`ifdef CALC_CHAIN_EN
    assign bus.rf_wsel   = rf_wsel_q;
`else
    assign bus.rf_wsel   = 1'b0;
`endif
endmodule
